// File: rtl/onchip_mem_pkg.sv
// Shared definitions for the on-chip RAM stream reader: default widths and FSM encoding.
package onchip_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CSUM_W     = DATA_W_DEF;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain
  } state_e;

endpackage

// File: rtl/onchip_mem_stream_reader_if.sv
// Command, RAM (Avalon-MM s1) and stream (Avalon-ST) signals of the stream reader.
// STREAM_READER_CSUM_EN adds the csum status signal.
interface onchip_mem_stream_reader_if
  import onchip_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic                cmd_valid;
  logic                cmd_ready;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [ADDR_W:0]     cmd_len;

  logic [ADDR_W-1:0]   mem_address;
  logic                mem_chipselect;
  logic                mem_write;
  logic [DATA_W/8-1:0] mem_byteenable;
  logic                mem_clken;
  logic [DATA_W-1:0]   mem_readdata;

  logic                src_valid;
  logic                src_ready;
  logic [DATA_W-1:0]   src_data;
  logic                src_sop;
  logic                src_eop;

  logic                busy;
  logic                done;

`ifdef STREAM_READER_CSUM_EN
  logic [DATA_W-1:0]   csum;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, mem_readdata, src_ready,
    output cmd_ready, mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
    output src_valid, src_data, src_sop, src_eop, busy, done, csum
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, mem_readdata, src_ready,
    input  cmd_ready, mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
    input  src_valid, src_data, src_sop, src_eop, busy, done, csum
  );
`else
  modport master (
    input  cmd_valid, cmd_addr, cmd_len, mem_readdata, src_ready,
    output cmd_ready, mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
    output src_valid, src_data, src_sop, src_eop, busy, done
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, mem_readdata, src_ready,
    input  cmd_ready, mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
    input  src_valid, src_data, src_sop, src_eop, busy, done
  );
`endif

endinterface

// File: rtl/stream_reader_fifo.sv
// Show-ahead output buffer for the stream reader; carries {data, sop, eop} per entry.
module stream_reader_fifo #(
  parameter int unsigned Width = 34,
  parameter int unsigned Depth = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [Width-1:0]       wdata,
  input  logic                   pop,
  output logic [Width-1:0]       rdata,
  output logic                   empty,
  output logic [$clog2(Depth):0] count
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q, count_d;
  logic [Width-1:0] mem_q [Depth];
  logic full, wr_en, rd_en;

  assign full  = (count_q == (PtrW + 1)'(Depth));
  assign empty = (count_q == '0);
  // A pop in the same cycle frees the slot, so a full buffer still accepts the push.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (wr_en && !rd_en) begin
      count_d = count_q + (PtrW + 1)'(1);
    end else if (!wr_en && rd_en) begin
      count_d = count_q - (PtrW + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/onchip_mem_stream_reader.sv
// Avalon-MM read master that streams {addr, len} word runs from on-chip RAM onto Avalon-ST.
// Define STREAM_READER_CSUM_EN to add a running modular checksum of transferred beats.
module onchip_mem_stream_reader
  import onchip_mem_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned READ_LATENCY = 1
) (
  input logic                        clk,
  input logic                        reset_n,
  onchip_mem_stream_reader_if.master bus
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic valid;
    logic sop;
    logic eop;
  } tag_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic              first_q, first_d;
  logic              zero_done_q, zero_done_d;
  tag_t              pipe_q [READ_LATENCY];
  tag_t              pipe_d [READ_LATENCY];

  logic [CntW-1:0]   fifo_count, inflight;
  logic              fifo_empty, fifo_pop;
  logic [DATA_W+1:0] fifo_rdata;
  logic              cmd_accept, credit_ok, issue, last_issue, drain_done;
  tag_t              pipe_exit;

  assign cmd_accept = bus.cmd_valid && bus.cmd_ready;
  assign last_issue = (remaining_q == (ADDR_W + 1)'(1));
  assign pipe_exit  = pipe_q[READ_LATENCY-1];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + CntW'(pipe_q[i].valid);
    end
  end

  // Every outstanding read owns a buffer slot, so readdata never needs to stall.
  assign credit_ok = ({1'b0, fifo_count} + {1'b0, inflight}) < (CntW + 1)'(FIFO_DEPTH);
  assign issue     = (state_q == StIssue) && (remaining_q != '0) && credit_ok;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    first_d     = first_q;
    zero_done_d = 1'b0;
    drain_done  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_accept) begin
          addr_d      = bus.cmd_addr;
          remaining_d = bus.cmd_len;
          first_d     = 1'b1;
          if (bus.cmd_len == '0) begin
            zero_done_d = 1'b1;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (issue) begin
          addr_d      = addr_q + ADDR_W'(1);
          remaining_d = remaining_q - (ADDR_W + 1)'(1);
          first_d     = 1'b0;
          if (last_issue) state_d = StDrain;
        end
      end
      StDrain: begin
        if (fifo_empty && (inflight == '0)) begin
          drain_done = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pipe_d[0] = {issue, issue && first_q, issue && last_issue};
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      first_q     <= 1'b0;
      zero_done_q <= 1'b0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      first_q     <= first_d;
      zero_done_q <= zero_done_d;
      for (int i = 0; i < READ_LATENCY; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  stream_reader_fifo #(
    .Width(DATA_W + 2),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (pipe_exit.valid),
    .wdata  ({bus.mem_readdata, pipe_exit.sop, pipe_exit.eop}),
    .pop    (fifo_pop),
    .rdata  (fifo_rdata),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign fifo_pop = bus.src_valid && bus.src_ready;

  assign bus.cmd_ready      = (state_q == StIdle);
  assign bus.mem_address    = addr_q;
  assign bus.mem_chipselect = issue;
  assign bus.mem_write      = 1'b0;
  assign bus.mem_byteenable = '1;
  assign bus.mem_clken      = 1'b1;
  assign bus.src_valid      = !fifo_empty;
  assign bus.src_data       = fifo_rdata[DATA_W+1:2];
  assign bus.src_sop        = fifo_rdata[1];
  assign bus.src_eop        = fifo_rdata[0];
  assign bus.busy           = (state_q != StIdle);
  assign bus.done           = drain_done || zero_done_q;

`ifdef STREAM_READER_CSUM_EN
  logic [DATA_W-1:0] csum_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csum_q <= '0;
    end else if (cmd_accept) begin
      csum_q <= '0;
    end else if (fifo_pop) begin
      csum_q <= csum_q + bus.src_data;
    end
  end

  assign bus.csum = csum_q;
`endif

endmodule

// File: tb/tb_onchip_mem_stream_reader.sv
// Scoreboard bench for onchip_mem_stream_reader with a behavioural 1024x32 RAM (latency 1).
module tb_onchip_mem_stream_reader;
  import onchip_mem_pkg::*;

  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LAT   = 1;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  onchip_mem_stream_reader_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();

  onchip_mem_stream_reader #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .FIFO_DEPTH  (DEPTH),
    .READ_LATENCY(LAT)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (mif)
  );

  logic [DW-1:0] ram [1 << AW];
  logic [DW-1:0] rdata;
  always @(posedge clk) if (mif.mem_chipselect) rdata <= ram[mif.mem_address];
  assign mif.mem_readdata = rdata;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } beat_t;

  beat_t         exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic expect_cmd(input logic [AW-1:0] addr, input int len);
    beat_t e;
    logic [AW-1:0] a;
    for (int i = 0; i < len; i++) begin
      a      = addr + AW'(i);
      e.data = ram[a];
      e.sop  = (i == 0);
      e.eop  = (i == len - 1);
      exp_q.push_back(e);
      exp_addr_q.push_back(a);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec += 9;
    if (mif.cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset cmd_ready got %b want 1", mif.cmd_ready); end
    if (mif.mem_address !== '0) begin n_err++; $display("FAIL reset mem_address got %h want 0", mif.mem_address); end
    if (mif.mem_chipselect !== 1'b0) begin n_err++; $display("FAIL reset chipselect got %b want 0", mif.mem_chipselect); end
    if (mif.src_valid !== 1'b0) begin n_err++; $display("FAIL reset src_valid got %b want 0", mif.src_valid); end
    if (mif.busy !== 1'b0) begin n_err++; $display("FAIL reset busy got %b want 0", mif.busy); end
    if (mif.done !== 1'b0) begin n_err++; $display("FAIL reset done got %b want 0", mif.done); end
    if (mif.mem_write !== 1'b0) begin n_err++; $display("FAIL tie mem_write got %b want 0", mif.mem_write); end
    if (mif.mem_byteenable !== 4'hF) begin n_err++; $display("FAIL tie byteenable got %h want f", mif.mem_byteenable); end
    if (mif.mem_clken !== 1'b1) begin n_err++; $display("FAIL tie clken got %b want 1", mif.mem_clken); end
    @(posedge clk); #1 reset_n = 1'b1;
  endtask

  // bp=1 holds src_ready high only one cycle in three.
  task automatic test_stream(input string name, input logic [AW-1:0] addr, input int len, input bit bp);
    int done_cnt = 0, done_k = -1, first_k = -1, last_k = -1, beats = 0, issued = 0;
    bit stall_seen = 1'b0, prev_hold = 1'b0;
    beat_t prev, got, e;
    logic [AW-1:0] ea;
    exp_q.delete(); exp_addr_q.delete();
    expect_cmd(addr, len);
    mif.src_ready = 1'b1;
    @(posedge clk); #1;
    mif.cmd_valid = 1'b1; mif.cmd_addr = addr; mif.cmd_len = (AW + 1)'(len);
    @(posedge clk); #1 mif.cmd_valid = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      got = {mif.src_data, mif.src_sop, mif.src_eop};
      if (prev_hold) begin
        n_vec++;
        if (got !== prev) begin n_err++; $display("FAIL %s hold-stable got %h want %h", name, got, prev); end
      end
      if (mif.mem_chipselect) begin
        issued++;
        ea = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 'x;
        n_vec += 2;
        if (mif.mem_address !== ea) begin n_err++; $display("FAIL %s address got %h want %h", name, mif.mem_address, ea); end
        if (issued - beats > DEPTH) begin n_err++; $display("FAIL %s credit outstanding got %0d want <=%0d", name, issued - beats, DEPTH); end
      end else if (mif.busy && issued < len) begin
        stall_seen = 1'b1;
      end
      if (mif.src_valid && mif.src_ready) begin
        if (first_k < 0) first_k = k;
        last_k = k;
        beats++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        n_vec++;
        if (got !== e) begin n_err++; $display("FAIL %s beat got %h/%b%b want %h/%b%b", name, got.data, got.sop, got.eop, e.data, e.sop, e.eop); end
      end
      prev_hold = mif.src_valid && !mif.src_ready;
      prev      = got;
      if (mif.done) begin done_cnt++; if (done_k < 0) done_k = k; end
      if (done_k >= 0 && k >= done_k + 3) break;
      @(posedge clk); #1 mif.src_ready = bp ? ((k + 1) % 3 == 0) : 1'b1;
    end
    n_vec += 2;
    if (done_cnt != 1) begin n_err++; $display("FAIL %s done pulses got %0d want 1", name, done_cnt); end
    if (beats != len || exp_q.size() != 0) begin n_err++; $display("FAIL %s beat count got %0d want %0d", name, beats, len); end
    if (bp) begin
      n_vec++;
      if (!stall_seen) begin n_err++; $display("FAIL %s issue stall got 0 want 1", name); end
    end else begin
      n_vec += 3;
      if (first_k != LAT + 1) begin n_err++; $display("FAIL %s first beat cycle got %0d want %0d", name, first_k, LAT + 1); end
      if (last_k != LAT + len) begin n_err++; $display("FAIL %s last beat cycle got %0d want %0d", name, last_k, LAT + len); end
      if (done_k != LAT + len + 1) begin n_err++; $display("FAIL %s done cycle got %0d want %0d", name, done_k, LAT + len + 1); end
    end
  endtask

  task automatic test_len0;
    bit cs_seen = 1'b0, v_seen = 1'b0;
    int done_cnt = 0, done_k = -1;
    @(posedge clk); #1;
    mif.cmd_valid = 1'b1; mif.cmd_addr = 10'd7; mif.cmd_len = '0;
    @(posedge clk); #1 mif.cmd_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      cs_seen |= mif.mem_chipselect;
      v_seen  |= mif.src_valid;
      if (mif.done) begin done_cnt++; if (done_k < 0) done_k = k; end
    end
    n_vec += 4;
    if (cs_seen) begin n_err++; $display("FAIL len0 chipselect got 1 want 0"); end
    if (v_seen) begin n_err++; $display("FAIL len0 src_valid got 1 want 0"); end
    if (done_cnt != 1) begin n_err++; $display("FAIL len0 done pulses got %0d want 1", done_cnt); end
    if (done_k != 0) begin n_err++; $display("FAIL len0 done cycle got %0d want 0", done_k); end
  endtask

  task automatic test_busy_hold;
    int done_cnt = 0, first_done = -1, ready_k = -1;
    bit b_taken = 1'b0;
    beat_t got, e;
    exp_q.delete(); exp_addr_q.delete();
    expect_cmd(10'd100, 4);
    expect_cmd(10'd200, 3);
    mif.src_ready = 1'b1;
    @(posedge clk); #1;
    mif.cmd_valid = 1'b1; mif.cmd_addr = 10'd100; mif.cmd_len = 11'd4;
    @(posedge clk); #1;
    mif.cmd_addr = 10'd200; mif.cmd_len = 11'd3;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (mif.cmd_valid && mif.cmd_ready && !b_taken) ready_k = k;
      if (mif.src_valid && mif.src_ready) begin
        got = {mif.src_data, mif.src_sop, mif.src_eop};
        e   = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        n_vec++;
        if (got !== e) begin n_err++; $display("FAIL hold beat got %h/%b%b want %h/%b%b", got.data, got.sop, got.eop, e.data, e.sop, e.eop); end
      end
      if (mif.done) begin done_cnt++; if (first_done < 0) first_done = k; end
      if (done_cnt == 2) break;
      @(posedge clk); #1;
      if (ready_k >= 0 && !b_taken) begin b_taken = 1'b1; mif.cmd_valid = 1'b0; end
    end
    mif.cmd_valid = 1'b0;
    n_vec += 3;
    if (ready_k != first_done + 1) begin n_err++; $display("FAIL hold cmd_ready cycle got %0d want %0d", ready_k, first_done + 1); end
    if (done_cnt != 2) begin n_err++; $display("FAIL hold done pulses got %0d want 2", done_cnt); end
    if (exp_q.size() != 0) begin n_err++; $display("FAIL hold leftover beats got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid;
    bit d_seen = 1'b0, v_seen = 1'b0;
    mif.src_ready = 1'b1;
    @(posedge clk); #1;
    mif.cmd_valid = 1'b1; mif.cmd_addr = '0; mif.cmd_len = 11'd16;
    @(posedge clk); #1 mif.cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    n_vec += 6;
    if (mif.cmd_ready !== 1'b1) begin n_err++; $display("FAIL midrst cmd_ready got %b want 1", mif.cmd_ready); end
    if (mif.mem_address !== '0) begin n_err++; $display("FAIL midrst mem_address got %h want 0", mif.mem_address); end
    if (mif.mem_chipselect !== 1'b0) begin n_err++; $display("FAIL midrst chipselect got %b want 0", mif.mem_chipselect); end
    if (mif.src_valid !== 1'b0) begin n_err++; $display("FAIL midrst src_valid got %b want 0", mif.src_valid); end
    if (mif.busy !== 1'b0) begin n_err++; $display("FAIL midrst busy got %b want 0", mif.busy); end
    if (mif.done !== 1'b0) begin n_err++; $display("FAIL midrst done got %b want 0", mif.done); end
    @(posedge clk); #1 reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      d_seen |= mif.done;
      v_seen |= mif.src_valid;
    end
    n_vec += 2;
    if (d_seen) begin n_err++; $display("FAIL midrst done after reset got 1 want 0"); end
    if (v_seen) begin n_err++; $display("FAIL midrst src_valid after reset got 1 want 0"); end
  endtask

`ifdef STREAM_READER_CSUM_EN
  task automatic test_csum;
    test_stream("csum8", 10'd0, 8, 1'b0);
    n_vec++;
    if (mif.csum !== 32'd28) begin n_err++; $display("FAIL csum8 got %0d want 28", mif.csum); end
    ram[10] = 32'hFFFF_FFFF;
    ram[11] = 32'd1;
    test_stream("csumwrap", 10'd10, 2, 1'b0);
    n_vec++;
    if (mif.csum !== 32'd0) begin n_err++; $display("FAIL csumwrap got %h want 0", mif.csum); end
    ram[10] = 32'd10;
    ram[11] = 32'd11;
  endtask
`endif

  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = DW'(i);
    mif.cmd_valid = 1'b0;
    mif.cmd_addr  = '0;
    mif.cmd_len   = '0;
    mif.src_ready = 1'b0;
    test_reset();
    test_stream("basic", 10'd0, 8, 1'b0);
    test_stream("wrap", 10'd1022, 4, 1'b0);
    test_stream("backpressure", 10'd0, 16, 1'b1);
    test_len0();
    test_stream("len1", 10'd5, 1, 1'b0);
    test_busy_hold();
    test_reset_mid();
    test_stream("recover", 10'd300, 5, 1'b0);
`ifdef STREAM_READER_CSUM_EN
    test_csum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
